// File: rtl/load_store_pkg.sv
// Shared definitions for the RV32I load/store datapath: func3 encodings, load FSM states and
// the small alignment/legality helpers used by the load side.
package load_store_pkg;

  localparam int unsigned XLEN = 32;

  // Load func3 encodings
  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  // Store func3 encodings
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StWb,
    StFault
  } load_state_e;

  function automatic logic load_func3_legal(input logic [2:0] f3);
    return (f3 == F3Lb) || (f3 == F3Lh) || (f3 == F3Lw) || (f3 == F3Lbu) || (f3 == F3Lhu);
  endfunction

  // Only meaningful for legal encodings; bytes are always aligned.
  function automatic logic load_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    if (f3 == F3Lh || f3 == F3Lhu) ok = ~off[0];
    if (f3 == F3Lw)                ok = (off == 2'b00);
    return ok;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a loaded memory word.
module load_extract
  import load_store_pkg::*;
(
  input  logic [XLEN-1:0] mem_word_i,
  input  logic [1:0]      byte_off_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_word_i[7:0];
    unique case (byte_off_i)
      2'd0: byte_v = mem_word_i[7:0];
      2'd1: byte_v = mem_word_i[15:8];
      2'd2: byte_v = mem_word_i[23:16];
      2'd3: byte_v = mem_word_i[31:24];
      default: byte_v = mem_word_i[7:0];
    endcase
    half_v = byte_off_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

    data_o = mem_word_i;
    case (func3_i)
      F3Lb:    data_o = {{24{byte_v[7]}}, byte_v};
      F3Lh:    data_o = {{16{half_v[15]}}, half_v};
      F3Lbu:   data_o = {24'd0, byte_v};
      F3Lhu:   data_o = {16'd0, half_v};
      default: data_o = mem_word_i;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle RV32I load engine: address check, single word read, bounded response wait,
// then one registered write pulse to the register file.
module load_unit
  import load_store_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [XLEN-1:0] base_addr,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      func3,
  input  logic [4:0]      rd,
  output logic            mem_read_enable,
  output logic [XLEN-1:0] mem_address,
  input  logic            mem_read_valid,
  input  logic [XLEN-1:0] mem_read_data,
  output logic            reg_write,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            load_misaligned,
  output logic            load_fault
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  load_state_e     state_q, state_d;
  logic [XLEN-1:0] ea_q, ea_d;
  logic [2:0]      func3_q, func3_d;
  logic [4:0]      rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      write_reg_q, write_reg_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic            misaligned_q, misaligned_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] ea_in;
  logic [XLEN-1:0] extracted;
  logic            capture;

  assign ea_in = base_addr + imm;

  load_extract u_extract (
    .mem_word_i (mem_read_data),
    .byte_off_i (ea_q[1:0]),
    .func3_i    (func3_q),
    .data_o     (extracted)
  );

  always_comb begin
    state_d      = state_q;
    ea_d         = ea_q;
    func3_d      = func3_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    misaligned_d = 1'b0;
    fault_d      = 1'b0;
    capture      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          ea_d    = ea_in;
          func3_d = func3;
          rd_d    = rd;
          if (load_func3_legal(func3) && load_aligned(func3, ea_in[1:0])) begin
            state_d = StIssue;
          end else begin
            state_d      = StFault;
            misaligned_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (mem_read_valid) begin
          capture = 1'b1;
        end else begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (mem_read_valid) begin
          capture = 1'b1;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StFault;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb:    state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered so the write pulse lines up with the WB state.
    if (capture) begin
      state_d      = StWb;
      reg_write_d  = (rd_q != 5'd0);
      write_reg_d  = rd_q;
      write_data_d = extracted;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      ea_q         <= '0;
      func3_q      <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ea_q         <= ea_d;
      func3_q      <= func3_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
    end
  end

  assign load_ready      = (state_q == StIdle);
  assign mem_read_enable = (state_q == StIssue);
  assign mem_address     = (state_q == StIssue) ? {ea_q[XLEN-1:2], 2'b00} : '0;
  assign reg_write       = reg_write_q;
  assign write_reg       = write_reg_q;
  assign write_data      = write_data_q;
  assign load_misaligned = misaligned_q;
  assign load_fault      = fault_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios plus randomized loads checked against
// a byte-level reference model.
module tb_load_unit;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] base_addr;
  logic [31:0] imm;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic        mem_read_enable;
  logic [31:0] mem_address;
  logic        mem_read_valid;
  logic [31:0] mem_read_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        load_misaligned;
  logic        load_fault;

  int checks = 0;
  int errors = 0;

  load_unit #(.TIMEOUT(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .base_addr       (base_addr),
    .imm             (imm),
    .func3           (func3),
    .rd              (rd),
    .mem_read_enable (mem_read_enable),
    .mem_address     (mem_address),
    .mem_read_valid  (mem_read_valid),
    .mem_read_data   (mem_read_data),
    .reg_write       (reg_write),
    .write_reg       (write_reg),
    .write_data      (write_data),
    .load_misaligned (load_misaligned),
    .load_fault      (load_fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: pick the addressed bytes, then extend by the load kind.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] v;
    v = word >> (8 * int'(off));
    case (f3)
      3'd0:    return 32'($signed(v[7:0]));
      3'd1:    return 32'($signed(v[15:0]));
      3'd4:    return v % 32'h100;
      3'd5:    return v % 32'h1_0000;
      default: return word;
    endcase
  endfunction

  function automatic bit ref_ok(input logic [31:0] ea, input logic [2:0] f3);
    int size;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << int'(f3[1:0]);
    return (ea % size) == 0;
  endfunction

  // One complete load; lat = cycles between ISSUE and the response (0 = same cycle).
  task automatic do_load(input logic [31:0] b, input logic [31:0] i, input logic [2:0] f3,
                         input logic [4:0] r, input logic [31:0] word, input int lat);
    logic [31:0] ea;
    logic [31:0] exp;
    ea  = b + i;
    exp = ref_load(word, ea[1:0], f3);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_load: got %b want 1", load_ready);
    end
    load_valid = 1'b1; base_addr = b; imm = i; func3 = f3; rd = r;
    tick();
    load_valid = 1'b0; base_addr = $urandom; imm = $urandom;
    if (!ref_ok(ea, f3)) begin
      checks++;
      if (load_misaligned !== 1'b1 || mem_read_enable !== 1'b0 || reg_write !== 1'b0
          || load_fault !== 1'b0) begin
        errors++;
        $display("FAIL misaligned_pulse: mis=%b en=%b wr=%b flt=%b want 1 0 0 0 (ea=%h f3=%0d)",
                 load_misaligned, mem_read_enable, reg_write, load_fault, ea, f3);
      end
      tick();
      checks++;
      if (load_ready !== 1'b1 || load_misaligned !== 1'b0 || reg_write !== 1'b0) begin
        errors++;
        $display("FAIL misaligned_return: ready=%b mis=%b wr=%b want 1 0 0",
                 load_ready, load_misaligned, reg_write);
      end
      return;
    end
    checks++;
    if (mem_read_enable !== 1'b1 || mem_address !== {ea[31:2], 2'b00}
        || load_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL issue: en=%b addr=%h mis=%b want 1 %h 0", mem_read_enable, mem_address,
               load_misaligned, {ea[31:2], 2'b00});
    end
    for (int k = 0; k < lat; k++) begin
      tick();
      checks++;
      if (mem_read_enable !== 1'b0 || reg_write !== 1'b0) begin
        errors++;
        $display("FAIL wait_quiet: en=%b wr=%b want 0 0", mem_read_enable, reg_write);
      end
    end
    mem_read_valid = 1'b1; mem_read_data = word;
    tick();
    mem_read_valid = 1'b0; mem_read_data = $urandom;
    checks++;
    if (reg_write !== (r != 5'd0)) begin
      errors++;
      $display("FAIL wb_pulse: reg_write=%b want %b (rd=%0d)", reg_write, r != 5'd0, r);
    end
    if (r != 5'd0) begin
      checks++;
      if (write_reg !== r || write_data !== exp) begin
        errors++;
        $display("FAIL wb_data: rd=%0d data=%h want rd=%0d data=%h (f3=%0d ea=%h word=%h)",
                 write_reg, write_data, r, exp, f3, ea, word);
      end
    end
    tick();
    checks++;
    if (reg_write !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL wb_return: wr=%b ready=%b want 0 1", reg_write, load_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (load_ready !== 1'b1 || mem_read_enable !== 1'b0 || mem_address !== 32'd0
        || reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0
        || load_misaligned !== 1'b0 || load_fault !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b en=%b addr=%h wr=%b wreg=%0d wdata=%h mis=%b flt=%b",
               tag, load_ready, mem_read_enable, mem_address, reg_write, write_reg, write_data,
               load_misaligned, load_fault);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset_values");
  endtask

  task automatic test_directed_extract();
    do_load(32'h100, 32'd3, 3'd0, 5'd1, 32'h8011_2233, 1);  // LB -> FFFFFF80
    do_load(32'h100, 32'd3, 3'd4, 5'd2, 32'h8011_2233, 1);  // LBU -> 80
    do_load(32'h100, 32'd2, 3'd5, 5'd3, 32'h8011_2233, 0);  // LHU -> 8011
    do_load(32'h100, 32'd0, 3'd1, 5'd4, 32'h8011_2233, 2);  // LH -> 2233
    do_load(32'h100, 32'd2, 3'd1, 5'd6, 32'h8011_2233, 1);  // LH -> FFFF8011
  endtask

  task automatic test_misaligned();
    do_load(32'h102, 32'd0, 3'd2, 5'd7, 32'h1234_5678, 0);
    do_load(32'h100, 32'd0, 3'd3, 5'd7, 32'h1234_5678, 0);
    do_load(32'h101, 32'd0, 3'd5, 5'd7, 32'h1234_5678, 0);
    do_load(32'h100, 32'd0, 3'd7, 5'd7, 32'h1234_5678, 0);
  endtask

  task automatic test_back_to_back();
    do_load(32'h200, 32'd0, 3'd2, 5'd0, 32'h1111_2222, 0);
    do_load(32'h200, 32'd4, 3'd2, 5'd5, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_wraparound();
    do_load(32'hFFFF_FFFC, 32'd8, 3'd2, 5'd9, 32'hCAFE_F00D, 1);
    do_load(32'h0000_0004, 32'hFFFF_FFFB, 3'd0, 5'd10, 32'h7F00_00AA, 0);  // ea = 0xFFFFFFFF
  endtask

  task automatic test_timeout();
    int pulses;
    int first;
    int wr;
    pulses = 0; first = -1; wr = 0;
    load_valid = 1'b1; base_addr = 32'h300; imm = 32'd0; func3 = 3'd2; rd = 5'd11;
    tick();
    load_valid = 1'b0;
    for (int c = 1; c <= TO + 8; c++) begin
      if (load_fault === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (reg_write === 1'b1) wr++;
      tick();
    end
    checks++;
    if (pulses != 1 || wr != 0) begin
      errors++;
      $display("FAIL timeout_pulse: fault pulses=%0d writes=%0d want 1 0", pulses, wr);
    end
    checks++;
    if (first < int'(TO) + 1 || first > int'(TO) + 3) begin
      errors++;
      $display("FAIL timeout_latency: fault at cycle %0d want %0d..%0d", first, TO + 1, TO + 3);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ready: ready=%b want 1", load_ready);
    end
    mem_read_valid = 1'b1; mem_read_data = 32'h5555_AAAA;
    tick();
    mem_read_valid = 1'b0;
    tick();
    checks++;
    if (reg_write !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_response: wr=%b ready=%b want 0 1", reg_write, load_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    load_valid = 1'b1; base_addr = 32'h400; imm = 32'd1; func3 = 3'd0; rd = 5'd12;
    tick();
    load_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("reset_in_wait");
    mem_read_valid = 1'b1; mem_read_data = 32'hFFFF_FFFF;
    tick();
    mem_read_valid = 1'b0;
    checks++;
    if (reg_write !== 1'b0 || load_fault !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL stale_after_reset: wr=%b flt=%b ready=%b want 0 0 1",
               reg_write, load_fault, load_ready);
    end
  endtask

  task automatic test_random();
    logic [2:0] codes [8];
    for (int n = 0; n < 8; n++) codes[n] = 3'(n);
    for (int n = 0; n < 60; n++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 9) == 0) ? codes[$urandom_range(0, 7)]
         : codes[{$urandom_range(0, 1) == 1, 2'($urandom_range(0, 2))}];
      do_load($urandom, 32'($signed(12'($urandom))), f3, 5'($urandom), $urandom,
              $urandom_range(0, 2));
    end
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; base_addr = '0; imm = '0; func3 = '0; rd = '0;
    mem_read_valid = 1'b0; mem_read_data = '0;
    test_reset();
    test_directed_extract();
    test_misaligned();
    test_back_to_back();
    test_wraparound();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
